// File: rtl/mismatch_pkg.sv
// Purpose : shared types and constants for the mismatch monitor slice.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package mismatch_pkg;

   // Default width of the sample, error and cycle counters.
   localparam int DEFAULT_CNT_W = 32;

   // Monitor FSM state encoding.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_RUN    = 2'd1;
   localparam state_t ST_REPORT = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Purpose : up-counter that clears on clr and sticks at all-ones instead of wrapping.
// Latency : count reflects clr/inc one cycle after the sampling edge.
// Backpr. : none; inc is simply ignored once saturated.
// Ports   : clk, reset (sync, active-high), clr (priority over inc), inc, count[CNT_W].
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mismatch_monitor.sv
// Purpose : scores a DUT vector against a reference vector over a run and reports the totals.
// Latency : counters update one cycle after the sampled edge; rpt_valid rises the cycle after stop/limit.
// Backpr. : report is held frozen in REPORT until rpt_ready; start/stop/samples ignored meanwhile.
// Ports   : clk, reset (sync, active-high); start/stop run control; sample_en qualifies ref_in/dut_in;
//           running high in RUN; rpt_valid/rpt_ready report handshake; rpt_samples, rpt_errors,
//           rpt_first (run cycle of first mismatch), rpt_bits (sticky OR of ref_in ^ dut_in).
module mismatch_monitor
   import mismatch_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int CNT_W   = DEFAULT_CNT_W,
   parameter int MAX_CYC = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] ref_in,
   input  logic [WIDTH-1:0] dut_in,
   output logic             running,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_samples,
   output logic [CNT_W-1:0] rpt_errors,
   output logic [CNT_W-1:0] rpt_first,
   output logic [WIDTH-1:0] rpt_bits
);

   // Cycle index on which a limited run takes its last sample. Only meaningful when MAX_CYC != 0.
   localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] cycle;
   logic [CNT_W-1:0] samples;
   logic [CNT_W-1:0] errors;
   logic [CNT_W-1:0] first;
   logic [WIDTH-1:0] bits;
   logic [WIDTH-1:0] diff;
   logic             mismatch;
   logic             in_run;
   logic             begin_run;
   logic             at_limit;
   logic             sample_hit;
   logic             err_hit;

   assign diff       = ref_in ^ dut_in;
   assign mismatch   = |diff;
   assign in_run     = (state == ST_RUN);
   assign begin_run  = (state == ST_IDLE) && start;
   assign at_limit   = (MAX_CYC != 0) && (cycle == LAST_CYC);
   // The stop/limit cycle is still a RUN cycle, so its sample is counted before leaving.
   assign sample_hit = in_run && sample_en;
   assign err_hit    = sample_hit && mismatch;

   sat_counter #(.CNT_W(CNT_W)) u_cycle (
      .clk   (clk),
      .reset (reset),
      .clr   (begin_run),
      .inc   (in_run),
      .count (cycle)
   );

   sat_counter #(.CNT_W(CNT_W)) u_samples (
      .clk   (clk),
      .reset (reset),
      .clr   (begin_run),
      .inc   (sample_hit),
      .count (samples)
   );

   sat_counter #(.CNT_W(CNT_W)) u_errors (
      .clk   (clk),
      .reset (reset),
      .clr   (begin_run),
      .inc   (err_hit),
      .count (errors)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         first <= '0;
         bits  <= '0;
      end else begin
         case (state)
            ST_IDLE:   if (start)             state <= ST_RUN;
            ST_RUN:    if (stop || at_limit)  state <= ST_REPORT;
            ST_REPORT: if (rpt_ready)         state <= ST_IDLE;
            default:                          state <= ST_IDLE;
         endcase

         if (begin_run) begin
            first <= '0;
            bits  <= '0;
         end else if (err_hit) begin
            bits <= bits | diff;
            // errors only reads zero before the first mismatch of the run (it saturates, never wraps),
            // so first is captured exactly once.
            if (errors == '0) begin
               first <= cycle;
            end
         end
      end
   end

   // Report fields are the live registers: nothing increments outside RUN, so they stay frozen
   // through REPORT and keep the last result in IDLE until the next start clears them.
   assign running     = in_run;
   assign rpt_valid   = (state == ST_REPORT);
   assign rpt_samples = samples;
   assign rpt_errors  = errors;
   assign rpt_first   = first;
   assign rpt_bits    = bits;

endmodule
